pipeline_interlock_unit: RTL and testbench

//  Issue-side controller for the decode-stage pipeline register. Tracks in-flight register writes
//  in a per-register countdown scoreboard, stalls decode on RAW/WAW hazards, and squashes

---
 rtl/pipeline_interlock_unit.sv | 115 +++++++++++
 tb/tb_pipeline_interlock_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_interlock_unit.sv
// Decode-stage issue controller: per-register countdown scoreboard, RAW/WAW
// hazard stalls and a short squash window after a taken branch.
module pipeline_interlock_unit #(
    parameter int DEPTH        = 3,
    parameter int LOAD_EXTRA   = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dec_valid_IN,
    input  logic [2:0]  src_a_IN,
    input  logic        src_a_used_IN,
    input  logic [2:0]  src_b_IN,
    input  logic        src_b_used_IN,
    input  logic        wren_IN,
    input  logic [2:0]  writeAd_IN,
    input  logic        load_IN,
    input  logic        PC_load_IN,
    output logic        issue_OUT,
    output logic        stall_OUT,
    output logic        flush_OUT,
    output logic [7:0]  busy_mask_OUT,
    output logic [15:0] stall_cnt_OUT
);

    localparam int LatMax = DEPTH + LOAD_EXTRA;
    localparam int CW     = $clog2(LatMax + 1);
    localparam int FW     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [CW-1:0] LatAlu    = CW'(DEPTH);
    localparam logic [CW-1:0] LatLoad   = CW'(LatMax);
    localparam logic [FW-1:0] FlushInit = FW'(FLUSH_CYCLES - 1);

    typedef enum logic {
        RUN,
        FLUSH
    } state_e;

    state_e         state_q;
    logic [FW-1:0]  fcnt_q;
    logic [CW-1:0]  cnt_q [8];
    logic [CW-1:0]  cnt_d [8];
    logic [15:0]    stall_cnt_q;
    logic [7:0]     busy;
    logic [CW-1:0]  lat;
    logic           raw;
    logic           waw;

    always_comb begin
        for (int r = 0; r < 8; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
        lat = load_IN ? LatLoad : LatAlu;
        raw = (src_a_used_IN & busy[src_a_IN]) | (src_b_used_IN & busy[src_b_IN]);
        // WAW only when the older write would land after the new one
        waw = wren_IN & (cnt_q[writeAd_IN] > lat);
        flush_OUT = PC_load_IN | (state_q == FLUSH);
        stall_OUT = dec_valid_IN & (raw | waw) & ~flush_OUT;
        issue_OUT = dec_valid_IN & ~stall_OUT & ~flush_OUT;
    end

    always_comb begin
        for (int r = 0; r < 8; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
            if (issue_OUT && wren_IN && (writeAd_IN == 3'(r))) begin
                cnt_d[r] = lat;
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int r = 0; r < 8; r++) begin
            cnt_q[r] <= RST ? '0 : cnt_d[r];
        end
    end

    // A branch seen while already flushing restarts the squash window
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (PC_load_IN) begin
                        state_q <= FLUSH;
                        fcnt_q  <= FlushInit;
                    end
                end
                FLUSH: begin
                    if (PC_load_IN) begin
                        fcnt_q <= FlushInit;
                    end else if (fcnt_q == '0) begin
                        state_q <= RUN;
                    end else begin
                        fcnt_q <= fcnt_q - FW'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else if (stall_OUT && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign busy_mask_OUT = busy;
    assign stall_cnt_OUT = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_interlock_unit.sv
// Bench for pipeline_interlock_unit: directed scenarios with literal expectations,
// plus a cycle-timeline model (write completion cycles, flush horizon) checked every cycle.
module tb_pipeline_interlock_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        dec_valid_IN;
    logic [2:0]  src_a_IN;
    logic        src_a_used_IN;
    logic [2:0]  src_b_IN;
    logic        src_b_used_IN;
    logic        wren_IN;
    logic [2:0]  writeAd_IN;
    logic        load_IN;
    logic        PC_load_IN;
    logic        issue_OUT;
    logic        stall_OUT;
    logic        flush_OUT;
    logic [7:0]  busy_mask_OUT;
    logic [15:0] stall_cnt_OUT;

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 1'b0;

    pipeline_interlock_unit #(.DEPTH(3), .LOAD_EXTRA(1), .FLUSH_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST), .dec_valid_IN(dec_valid_IN),
        .src_a_IN(src_a_IN), .src_a_used_IN(src_a_used_IN),
        .src_b_IN(src_b_IN), .src_b_used_IN(src_b_used_IN),
        .wren_IN(wren_IN), .writeAd_IN(writeAd_IN), .load_IN(load_IN),
        .PC_load_IN(PC_load_IN), .issue_OUT(issue_OUT), .stall_OUT(stall_OUT),
        .flush_OUT(flush_OUT), .busy_mask_OUT(busy_mask_OUT), .stall_cnt_OUT(stall_cnt_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a register is busy from the cycle after issue until its write-completion cycle
    int now = 0;
    int done [8];
    int flushUntil = -100;
    int expStallCnt = 0;

    always @(negedge CLK) begin
        if (checkEn) begin
            logic [7:0] eBusy;
            int remW, lat;
            bit eRaw, eWaw, eFlush, eStall, eIssue;
            for (int r = 0; r < 8; r++) eBusy[r] = (now <= done[r]);
            lat    = load_IN ? 4 : 3;
            remW   = (now <= done[writeAd_IN]) ? done[writeAd_IN] - now + 1 : 0;
            eRaw   = (src_a_used_IN && eBusy[src_a_IN]) || (src_b_used_IN && eBusy[src_b_IN]);
            eWaw   = wren_IN && (remW > lat);
            eFlush = PC_load_IN || (now <= flushUntil);
            eStall = dec_valid_IN && (eRaw || eWaw) && !eFlush;
            eIssue = dec_valid_IN && !eStall && !eFlush;
            checkOutput("model issue", 16'(issue_OUT), 16'(eIssue));
            checkOutput("model stall", 16'(stall_OUT), 16'(eStall));
            checkOutput("model flush", 16'(flush_OUT), 16'(eFlush));
            checkOutput("model busy", 16'(busy_mask_OUT), 16'(eBusy));
            checkOutput("model stall_cnt", stall_cnt_OUT, 16'(expStallCnt));
            if (RST) begin
                for (int r = 0; r < 8; r++) done[r] = -100;
                flushUntil  = -100;
                expStallCnt = 0;
            end else begin
                if (eIssue && wren_IN) done[writeAd_IN] = now + lat;
                if (PC_load_IN) flushUntil = now + 2;
                if (eStall && expStallCnt < 65535) expStallCnt++;
            end
        end
        now++;
    end

    // Drive one cycle of inputs just after the edge, then wait to the sampling point
    task automatic applyStimulus(input bit rst, input bit valid, input logic [2:0] sa, input bit sau,
                                 input logic [2:0] sb, input bit sbu, input bit wr,
                                 input logic [2:0] wa, input bit ld, input bit pcl);
        @(posedge CLK);
        #1;
        RST = rst; dec_valid_IN = valid; src_a_IN = sa; src_a_used_IN = sau;
        src_b_IN = sb; src_b_used_IN = sbu; wren_IN = wr; writeAd_IN = wa;
        load_IN = ld; PC_load_IN = pcl;
        @(negedge CLK);
    endtask

    task automatic idleReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int r = 0; r < 8; r++) done[r] = -100;
        RST = 1'b1; dec_valid_IN = 0; src_a_IN = 0; src_a_used_IN = 0; src_b_IN = 0;
        src_b_used_IN = 0; wren_IN = 0; writeAd_IN = 0; load_IN = 0; PC_load_IN = 0;
        @(posedge CLK);
        #1;
        checkEn = 1'b1;
        @(negedge CLK);
        checkOutput("reset busy", 16'(busy_mask_OUT), 16'h0);
        checkOutput("reset stall_cnt", stall_cnt_OUT, 16'h0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("reset flush follows PC_load", 16'(flush_OUT), 16'h1);

        // RAW on a non-load write
        idleReset();
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 3, 0, 0);
        checkOutput("t1 issue c0", 16'(issue_OUT), 16'h1);
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(0, 1, 3, 1, 0, 0, 0, 0, 0, 0);
            checkOutput("t1 stall", 16'(stall_OUT), 16'h1);
        end
        applyStimulus(0, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("t1 issue c4", 16'(issue_OUT), 16'h1);
        checkOutput("t1 stall_cnt", stall_cnt_OUT, 16'd3);

        // RAW on a load through src B
        idleReset();
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 5, 1, 0);
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(0, 1, 0, 0, 5, 1, 0, 0, 0, 0);
            checkOutput("t2 stall", 16'(stall_OUT), 16'h1);
            checkOutput("t2 busy", 16'(busy_mask_OUT), 16'h20);
        end
        applyStimulus(0, 1, 0, 0, 5, 1, 0, 0, 0, 0);
        checkOutput("t2 issue c5", 16'(issue_OUT), 16'h1);

        // WAW: short write behind a pending load
        idleReset();
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 2, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 2, 0, 0);
        checkOutput("t3 stall c1", 16'(stall_OUT), 16'h1);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 2, 0, 0);
        checkOutput("t3 issue c2", 16'(issue_OUT), 16'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3 busy c3", 16'(busy_mask_OUT), 16'h04);
        for (int c = 4; c <= 6; c++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3 busy c6", 16'(busy_mask_OUT), 16'h00);

        // Single branch, then back-to-back branches
        for (int pass = 0; pass < 2; pass++) begin
            idleReset();
            for (int c = 0; c < 10; c++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
            checkOutput("t4 flush c10", 16'(flush_OUT), 16'h1);
            applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, pass == 1);
            checkOutput("t4 issue c11", 16'(issue_OUT), 16'h0);
            applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("t4 flush c12", 16'(flush_OUT), 16'h1);
            applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("t4 issue c13", 16'(issue_OUT), (pass == 0) ? 16'h1 : 16'h0);
            applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("t4 issue c14", 16'(issue_OUT), 16'h1);
        end

        // Branch masks a concurrent RAW hazard
        idleReset();
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        checkOutput("t5 stall", 16'(stall_OUT), 16'h0);
        checkOutput("t5 flush", 16'(flush_OUT), 16'h1);
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("t5 issue c4", 16'(issue_OUT), 16'h1);
        checkOutput("t5 stall_cnt", stall_cnt_OUT, 16'd0);

        // Reset during flush with writes in flight
        idleReset();
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 2, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 3, 1, 0);
        applyStimulus(0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("t6 stall c2", 16'(stall_OUT), 16'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6 busy before reset", 16'(busy_mask_OUT), 16'h0C);
        checkOutput("t6 flush before reset", 16'(flush_OUT), 16'h1);
        checkOutput("t6 stall_cnt before reset", stall_cnt_OUT, 16'd1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6 busy after reset", 16'(busy_mask_OUT), 16'h00);
        checkOutput("t6 flush after reset", 16'(flush_OUT), 16'h0);
        checkOutput("t6 stall_cnt after reset", stall_cnt_OUT, 16'd0);
        checkOutput("t6 issue after reset", 16'(issue_OUT), 16'h1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("t6 flush follows PC_load", 16'(flush_OUT), 16'h1);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
